// File: rtl/axis_gen_pkg.sv
// Shared types and constants for the AXI-stream packet generator.
// The LFSR taps encode x^64+x^63+x^61+x^60+1 for a right-shifting Galois register.
package axis_gen_pkg;

    typedef enum logic [1:0] {
        MODE_LFSR  = 2'd0,
        MODE_CNT   = 2'd1,
        MODE_IDX   = 2'd2,
        MODE_CONST = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/lfsr_nbit.sv
// Galois LFSR, reseedable. q_nxt is the value the register takes on the next
// enabled step, so the caller can register it as output data in the same cycle.
module lfsr_nbit
    import axis_gen_pkg::*;
#(
    parameter int               WIDTH = 64,
    parameter int               OUTW  = 64,
    parameter logic [WIDTH-1:0] SEED  = '1,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS)
) (
    input  logic            clk,
    input  logic            s_rst_n,
    input  logic            load,
    input  logic            enable,
    output logic [OUTW-1:0] q_nxt
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_step;

    always_comb begin
        state_step = {1'b0, state_q[WIDTH-1:1]} ^ (state_q[0] ? TAPS : '0);
    end

    assign q_nxt = state_step[OUTW-1:0];

    always_ff @(posedge clk) begin
        if (!s_rst_n || load) begin
            state_q <= SEED;
        end else if (enable) begin
            state_q <= state_step;
        end
    end

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-stream packet generator: fixed-length packets, programmable gap and count,
// four data patterns, graceful stop at packet boundaries. All outputs are registered.
module axis_pkt_gen
    import axis_gen_pkg::*;
#(
    parameter int          DATAW   = 64,
    parameter int          MAX_LEN = 256,
    parameter logic [63:0] SEED    = 64'hFEDCBA9876543210,
    parameter int          GAPW    = 8,
    parameter int          CNTW    = 16,
    localparam int         LENW    = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             s_rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       cfg_mode,
    input  logic [LENW-1:0]  cfg_len,
    input  logic [GAPW-1:0]  cfg_gap,
    input  logic [CNTW-1:0]  cfg_num_pkts,
    output logic [DATAW-1:0] m_data,
    output logic             m_vld,
    input  logic             m_rdy,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  pkt_cnt,
    output logic [1:0]       dbg_state
);

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [LENW-1:0]   len_q, len_d, beat_q, beat_d, beat_nxt, last_beat, len_clamped;
    logic [GAPW-1:0]   gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic [CNTW-1:0]   num_q, num_d, pkt_cnt_d, pkt_inc;
    logic [DATAW-1:0]  word_q, word_d, word_nxt, data_d, lfsr_nxt;
    logic              stop_q, stop_d, vld_d, last_d, done_d, hs;
    logic              lfsr_load, lfsr_en;

    lfsr_nbit #(
        .WIDTH (64),
        .OUTW  (DATAW),
        .SEED  (SEED),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr (
        .clk     (clk),
        .s_rst_n (s_rst_n),
        .load    (lfsr_load),
        .enable  (lfsr_en),
        .q_nxt   (lfsr_nxt)
    );

    function automatic logic [LENW-1:0] clamp_len(input logic [LENW-1:0] l);
        if (l == '0) return LENW'(1);
        if (l > LENW'(MAX_LEN)) return LENW'(MAX_LEN);
        return l;
    endfunction

    // Data word for the beat about to be presented; lf is the LFSR value for that beat.
    function automatic logic [DATAW-1:0] pattern(input mode_t mode, input logic [LENW-1:0] beat,
                                                 input logic [DATAW-1:0] word,
                                                 input logic [DATAW-1:0] lf);
        logic [63:0] beat_ext;
        beat_ext = 64'(beat);
        case (mode)
            MODE_LFSR: return lf;
            MODE_CNT:  return word;
            MODE_IDX:  return beat_ext[DATAW-1:0];
            default:   return SEED[DATAW-1:0];
        endcase
    endfunction

    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_d     = len_q;
        gap_d     = gap_q;
        num_d     = num_q;
        beat_d    = beat_q;
        word_d    = word_q;
        gap_cnt_d = gap_cnt_q;
        stop_d    = stop_q;
        pkt_cnt_d = pkt_cnt;
        data_d    = m_data;
        vld_d     = m_vld;
        last_d    = m_last;
        done_d    = 1'b0;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;

        hs          = m_vld & m_rdy;
        last_beat   = len_q - LENW'(1);
        beat_nxt    = m_last ? '0 : beat_q + LENW'(1);
        word_nxt    = word_q + DATAW'(1);
        pkt_inc     = (pkt_cnt == '1) ? pkt_cnt : pkt_cnt + CNTW'(1);
        len_clamped = clamp_len(cfg_len);

        case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                if (start && !stop) begin
                    mode_d    = mode_t'(cfg_mode);
                    len_d     = len_clamped;
                    gap_d     = cfg_gap;
                    num_d     = cfg_num_pkts;
                    pkt_cnt_d = '0;
                    beat_d    = '0;
                    word_d    = '0;
                    lfsr_load = 1'b1;
                    data_d    = pattern(mode_t'(cfg_mode), '0, '0, SEED[DATAW-1:0]);
                    last_d    = (len_clamped == LENW'(1));
                    vld_d     = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) stop_d = 1'b1;
                if (hs) begin
                    lfsr_en = (mode_q == MODE_LFSR);
                    beat_d  = beat_nxt;
                    word_d  = word_nxt;
                    data_d  = pattern(mode_q, beat_nxt, word_nxt, lfsr_nxt);
                    last_d  = (beat_nxt == last_beat);
                    if (m_last) begin
                        pkt_cnt_d = pkt_inc;
                        if ((num_q != '0 && pkt_inc == num_q) || stop_q || stop) begin
                            state_d = ST_IDLE;
                            vld_d   = 1'b0;
                            last_d  = 1'b0;
                            done_d  = 1'b1;
                            stop_d  = 1'b0;
                        end else if (gap_q != '0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = gap_q;
                            vld_d     = 1'b0;
                            last_d    = 1'b0;
                        end
                    end
                end
            end
            ST_GAP: begin
                // The next packet's first word is already in m_data; just release it.
                if (stop || stop_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    stop_d  = 1'b0;
                end else if (gap_cnt_q <= GAPW'(1)) begin
                    state_d = ST_RUN;
                    vld_d   = 1'b1;
                    last_d  = (beat_q == last_beat);
                end else begin
                    gap_cnt_d = gap_cnt_q - GAPW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_LFSR;
            len_q     <= LENW'(1);
            gap_q     <= '0;
            num_q     <= '0;
            beat_q    <= '0;
            word_q    <= '0;
            gap_cnt_q <= '0;
            stop_q    <= 1'b0;
            pkt_cnt   <= '0;
            m_data    <= '0;
            m_vld     <= 1'b0;
            m_last    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            num_q     <= num_d;
            beat_q    <= beat_d;
            word_q    <= word_d;
            gap_cnt_q <= gap_cnt_d;
            stop_q    <= stop_d;
            pkt_cnt   <= pkt_cnt_d;
            m_data    <= data_d;
            m_vld     <= vld_d;
            m_last    <= last_d;
            done      <= done_d;
            busy      <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed-plus-random bench for axis_pkt_gen; beats are captured by a monitor
// and compared with a packet-level reference model.
module tb_axis_pkt_gen;
    import axis_gen_pkg::*;

    localparam int          DATAW   = 32;
    localparam int          MAX_LEN = 16;
    localparam int          GAPW    = 4;
    localparam int          CNTW    = 8;
    localparam logic [63:0] SEED    = 64'hFEDCBA9876543210;
    localparam int          LENW    = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             s_rst_n, start, stop, m_rdy;
    logic [1:0]       cfg_mode;
    logic [LENW-1:0]  cfg_len;
    logic [GAPW-1:0]  cfg_gap;
    logic [CNTW-1:0]  cfg_num_pkts;
    logic [DATAW-1:0] m_data;
    logic             m_vld, m_last, busy, done;
    logic [CNTW-1:0]  pkt_cnt;
    logic [1:0]       dbg_state;

    axis_pkt_gen #(
        .DATAW(DATAW), .MAX_LEN(MAX_LEN), .SEED(SEED), .GAPW(GAPW), .CNTW(CNTW)
    ) dut (
        .clk(clk), .s_rst_n(s_rst_n), .start(start), .stop(stop),
        .cfg_mode(cfg_mode), .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_num_pkts(cfg_num_pkts),
        .m_data(m_data), .m_vld(m_vld), .m_rdy(m_rdy), .m_last(m_last),
        .busy(busy), .done(done), .pkt_cnt(pkt_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: beats, idle cycles before each beat, done pulses, stall stability.
    logic [DATAW-1:0] got_data[$];
    bit               got_last[$];
    int               got_gap[$];
    int               idle_run = 0;
    int               done_cnt = 0;
    bit               stall_q = 1'b0;
    logic [DATAW-1:0] stall_data;
    logic             stall_last;

    always @(negedge clk) begin
        if (s_rst_n === 1'b1) begin
            if (stall_q) begin
                chk("hold_vld", m_vld, 1);
                chk("hold_data", m_data, stall_data);
                chk("hold_last", m_last, stall_last);
            end
            if (done) begin
                done_cnt++;
                chk("done_vld_low", m_vld, 0);
            end
            if (m_vld && m_rdy) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                got_gap.push_back(idle_run);
                idle_run = 0;
            end else if (!m_vld) begin
                idle_run++;
            end
            stall_q    = m_vld && !m_rdy;
            stall_data = m_data;
            stall_last = m_last;
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic clear_mon();
        got_data.delete();
        got_last.delete();
        got_gap.delete();
        idle_run = 0;
        done_cnt = 0;
    endtask

    // Reference model: the polynomial applied as a right-shifting Galois register.
    function automatic logic [63:0] lfsr_step(input logic [63:0] x);
        logic [63:0] y;
        int exps[4] = '{64, 63, 61, 60};
        y = x >> 1;
        if (x[0]) foreach (exps[k]) y[exps[k]-1] = ~y[exps[k]-1];
        return y;
    endfunction

    logic [DATAW-1:0] exp_q[$];
    bit               exp_last[$];
    int               exp_gap[$];

    task automatic build_exp(input int mode, input int len_cfg, input int gap, input int npkts);
        int          len;
        logic [63:0] l;
        logic [63:0] w;
        logic [63:0] c;
        exp_q.delete(); exp_last.delete(); exp_gap.delete();
        len = (len_cfg == 0) ? 1 : (len_cfg > MAX_LEN) ? MAX_LEN : len_cfg;
        l = SEED;
        w = 0;
        c = SEED;
        for (int p = 0; p < npkts; p++) begin
            for (int i = 0; i < len; i++) begin
                case (mode)
                    0:       exp_q.push_back(l[DATAW-1:0]);
                    1:       exp_q.push_back(w[DATAW-1:0]);
                    2:       exp_q.push_back(DATAW'(i));
                    default: exp_q.push_back(c[DATAW-1:0]);
                endcase
                exp_last.push_back(i == len - 1);
                exp_gap.push_back((p > 0 && i == 0) ? gap : 0);
                w = w + 1;
                l = lfsr_step(l);
            end
        end
    endtask

    task automatic compare_run(input string tag);
        int n;
        chk({tag, "_nbeats"}, got_data.size(), exp_q.size());
        n = (got_data.size() < exp_q.size()) ? got_data.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data[%0d]", tag, i), got_data[i], exp_q[i]);
            chk($sformatf("%s_last[%0d]", tag, i), got_last[i], exp_last[i]);
            chk($sformatf("%s_gap[%0d]", tag, i), got_gap[i], exp_gap[i]);
        end
    endtask

    task automatic start_run(input int mode, input int len, input int gap, input int num);
        @(posedge clk); #1;
        cfg_mode = 2'(mode); cfg_len = LENW'(len); cfg_gap = GAPW'(gap); cfg_num_pkts = CNTW'(num);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        clear_mon();
        // Latched configuration must be immune to later changes.
        cfg_mode = 2'($urandom); cfg_len = LENW'($urandom); cfg_gap = GAPW'($urandom);
        cfg_num_pkts = CNTW'($urandom);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        @(negedge clk);
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_idle_timeout"}, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_beats(input string tag, input int nb, input int budget);
        int k = 0;
        while (got_data.size() < nb && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_beats_timeout"}, (got_data.size() >= nb), 1);
    endtask

    initial begin
        m_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_rdy = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nl;
        s_rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_mode = '0; cfg_len = '0; cfg_gap = '0; cfg_num_pkts = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", m_vld, 0);
        chk("rst_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_data", m_data, 0);
        @(posedge clk); #1;
        s_rst_n = 1'b1;

        // Counter mode, contiguous packets.
        start_run(1, 4, 0, 3);
        @(negedge clk);
        chk("start_latency_vld", m_vld, 1);
        wait_idle("cnt4", 200);
        build_exp(1, 4, 0, 3);
        compare_run("cnt4");
        chk("cnt4_pkt_cnt", pkt_cnt, 3);
        chk("cnt4_done", done_cnt, 1);

        // Beat-index mode with gap.
        start_run(2, 3, 2, 3);
        wait_idle("idx3", 200);
        build_exp(2, 3, 2, 3);
        compare_run("idx3");
        chk("idx3_pkt_cnt", pkt_cnt, 3);
        chk("idx3_done", done_cnt, 1);

        // LFSR, steady then random backpressure.
        start_run(0, 5, 1, 4);
        wait_idle("lfsr_rdy1", 300);
        build_exp(0, 5, 1, 4);
        compare_run("lfsr_rdy1");
        rand_rdy = 1'b1;
        start_run(0, 5, 1, 4);
        wait_idle("lfsr_rand", 1000);
        compare_run("lfsr_rand");
        chk("lfsr_rand_pkt_cnt", pkt_cnt, 4);

        for (int r = 0; r < 4; r++) begin
            int md, ln, gp, nm;
            md = $urandom_range(0, 3);
            ln = $urandom_range(0, MAX_LEN + 3);
            gp = $urandom_range(0, 3);
            nm = $urandom_range(1, 4);
            start_run(md, ln, gp, nm);
            wait_idle("rnd", 2000);
            build_exp(md, ln, gp, nm);
            compare_run($sformatf("rnd%0d", r));
            chk("rnd_pkt_cnt", pkt_cnt, nm);
            chk("rnd_done", done_cnt, 1);
        end
        rand_rdy = 1'b0;

        // Constant mode, unlimited, graceful stop inside packet 5.
        start_run(3, 8, 0, 0);
        wait_beats("stop5", 34, 500);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_idle("stop5", 200);
        build_exp(3, 8, 0, 5);
        compare_run("stop5");
        chk("stop5_pkt_cnt", pkt_cnt, 5);
        chk("stop5_done", done_cnt, 1);

        // Length clamping.
        start_run(2, 0, 0, 3);
        wait_idle("len0", 100);
        build_exp(2, 0, 0, 3);
        compare_run("len0");
        start_run(1, MAX_LEN + 5, 0, 1);
        wait_idle("lenmax", 200);
        build_exp(1, MAX_LEN + 5, 0, 1);
        compare_run("lenmax");

        // Start while busy is ignored.
        start_run(1, 4, 3, 2);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        cfg_mode = 2'd2; cfg_len = LENW'(1); cfg_num_pkts = CNTW'(9); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle("busy_start", 200);
        build_exp(1, 4, 3, 2);
        compare_run("busy_start");
        chk("busy_start_pkt_cnt", pkt_cnt, 2);
        chk("busy_start_done", done_cnt, 1);

        // Stop while idle is not remembered.
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_stop_busy", busy, 0);
        start_run(1, 2, 0, 2);
        wait_idle("after_idle_stop", 100);
        build_exp(1, 2, 0, 2);
        compare_run("after_idle_stop");
        chk("after_idle_stop_pkt_cnt", pkt_cnt, 2);

        // Stop during the gap ends at once.
        start_run(1, 2, 10, 0);
        wait_beats("gap_stop", 2, 100);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        @(negedge clk);
        chk("gap_stop_busy", busy, 0);
        repeat (2) @(negedge clk);
        chk("gap_stop_done", done_cnt, 1);
        chk("gap_stop_pkt_cnt", pkt_cnt, 1);
        chk("gap_stop_nbeats", got_data.size(), 2);

        // Reset mid-packet.
        start_run(1, 6, 0, 0);
        wait_beats("rst_mid", 3, 100);
        @(posedge clk); #1 s_rst_n = 1'b0;
        @(posedge clk); #1 s_rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_vld", m_vld, 0);
        chk("rst_mid_last", m_last, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_pkt_cnt", pkt_cnt, 0);
        nl = 0;
        foreach (got_last[i]) nl += got_last[i];
        chk("rst_mid_no_last", nl, 0);
        repeat (3) @(negedge clk);
        chk("rst_mid_stays_idle", m_vld, 0);
        start_run(1, 3, 0, 1);
        wait_idle("rst_restart", 100);
        build_exp(1, 3, 0, 1);
        compare_run("rst_restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_pkt_gen.md
AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 SHALL have parameter DATAW, 64, stream data width (1..64).
REQ-002 SHALL have parameter MAX_LEN, 256, maximum beats per packet (>=1).
REQ-003 SHALL have parameter SEED, 64'hFEDCBA9876543210, LFSR seed and constant-mode word.
REQ-004 SHALL have parameter GAPW, 8, width of the inter-packet gap field.
REQ-005 SHALL have parameter CNTW, 16, width of the packet-count fields.
REQ-006 SHALL have port clk  in  1  clock.
REQ-007 SHALL have port s_rst_n  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port start  in  1  single-cycle launch pulse.
REQ-009 SHALL have port stop  in  1  request graceful stop at the next packet boundary.
REQ-010 SHALL have port cfg_mode  in  2  data pattern: 0 LFSR, 1 running counter, 2 beat index, 3 constant.
REQ-011 SHALL have port cfg_len  in  LENW=$clog2(MAX_LEN+1)  beats per packet.
REQ-012 SHALL have port cfg_gap  in  GAPW  idle cycles between packets.
REQ-013 SHALL have port cfg_num_pkts  in  CNTW  packets to send; 0 = unlimited.
REQ-014 SHALL have ports m_data out DATAW, m_vld out 1, m_rdy in 1, m_last out 1: AXI-stream master.
REQ-015 SHALL have port busy out 1 (high outside IDLE), done out 1 (completion pulse), and pkt_cnt out CNTW (completed packets).

Function
REQ-016 SHALL implement FSM states IDLE, RUN, GAP.
REQ-017 SHALL, in IDLE with start=1 and stop=0, latch all cfg_* inputs, clear pkt_cnt, reseed the LFSR and clear the counters, then enter RUN, with m_vld=1 on the next cycle.
REQ-018 SHALL ignore start outside IDLE and while stop=1; cfg_* changes after latching SHALL have no effect.
REQ-019 SHALL treat a latched cfg_len of 0 as 1 and a value >MAX_LEN as MAX_LEN.
REQ-020 SHALL count a beat only on a handshake (m_vld & m_rdy); with m_vld=1 & m_rdy=0, m_data and m_last SHALL hold stable.
REQ-021 SHALL assert m_last on the beat with index len-1 only; a len of 1 gives m_last on every beat.
REQ-022 Data modes SHALL be as follows. LFSR: m_data = lfsr[DATAW-1:0], advancing one step per handshake. Counter: a word counter from 0 that +1 per handshake, wraps mod 2^DATAW and persists across packets. Index: the zero-extended in-packet beat index. Constant: SEED[DATAW-1:0].
REQ-023 SHALL, on the last-beat handshake, increment pkt_cnt (saturating at 2^CNTW-1); if cfg_gap>0 it SHALL enter GAP with m_vld=0 for exactly cfg_gap cycles, otherwise it SHALL stay in RUN and present the next first beat on the following cycle with m_vld held high.
REQ-024 SHALL go to IDLE on completion of packet cfg_num_pkts (nonzero), pulsing done for one cycle on the cycle after the last handshake, with m_vld=0.
REQ-025 SHALL register stop as sticky while busy; it SHALL take effect at the last-beat handshake, or immediately if in GAP, going to IDLE and pulsing done; stop SHALL never truncate a packet.
REQ-026 SHALL take no action on stop in IDLE and SHALL NOT carry it over to a later start.
REQ-027 SHALL drive all outputs from registers; the start to first m_vld latency SHALL be 1 cycle.

Reset
REQ-028 SHALL, with s_rst_n=0 at a clock edge, enter IDLE and clear m_vld, m_last, busy, done, pkt_cnt, the beat counter, the word counter and sticky stop; it SHALL load the LFSR with SEED and set m_data to 0.
REQ-029 SHALL, on reset mid-packet, abort immediately with no m_last, and SHALL require a new start after reset.

Structure
REQ-030 SHALL place the mode enum (MODE_LFSR, MODE_CNT, MODE_IDX, MODE_CONST), the FSM state enum and the 64-bit LFSR tap constant (x^64+x^63+x^61+x^60+1) in package axis_gen_pkg.
REQ-031 SHALL instantiate one sub-module, lfsr_nbit (WIDTH=64, SEED, enable, load inputs), with advancing driven by the handshake in LFSR mode.

Verification
REQ-032 Mode 1, len 4, gap 0, num 3, m_rdy=1 SHALL give 12 contiguous beats with data 0..11, m_last on beats 3/7/11, pkt_cnt=3 and one done pulse.
REQ-033 Mode 2, len 3, gap 2 SHALL give data 0,1,2 per packet with exactly 2 m_vld=0 cycles between packets.
REQ-034 Mode 0, with m_rdy toggled randomly, SHALL give a beat sequence identical to the m_rdy=1 run, and m_data SHALL be stable whenever m_vld=1 & m_rdy=0.
REQ-035 Mode 3, len 8, num 0, with stop asserted at beat 2 of packet 5, SHALL finish packet 5 (8 beats, m_last), then idle with pkt_cnt=5 and one done pulse.
REQ-036 cfg_len=0 SHALL give 1-beat packets, and cfg_len=MAX_LEN+5 SHALL give MAX_LEN beats; a start while busy SHALL be ignored, with the counts unchanged.
REQ-037 Reset at beat 3 of 6 SHALL drop m_vld next cycle with no m_last; a following start SHALL restart from data 0 (mode 1).
